// File: rtl/mprj_io_pkg.sv
// Shared definitions for the user-project GPIO input-conditioning stage:
// edge-mode encodings, parameter defaults and the edge-match helper.
package mprj_io_pkg;

    // Pad-count defaults follow the pad-array sizes of the user project.
    localparam int MPRJ_TOTAL_PADS_DEF = 38;
    localparam int MPRJ_AREA1_PADS_DEF = 19;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_W_DEF      = 4;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_match(input logic [1:0] mode,
                                        input logic       prev,
                                        input logic       cur);
        logic rise;
        logic fall;
        rise = !prev && cur;
        fall = prev && !cur;
        return (rise && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
               (fall && (mode == EDGE_FALL || mode == EDGE_BOTH));
    endfunction

endpackage

// File: rtl/mprj_io_cond_ch.sv
// One pad channel: synchroniser, debounce filter, edge detector and sticky
// interrupt flag. Hold freezes the filter and flag-set path, not the sync chain.
module mprj_io_cond_ch
    import mprj_io_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_W      = FILT_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              io_in_raw,
    input  logic              filt_en,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [1:0]        edge_mode,
    input  logic              irq_clr,
    input  logic              hold,
    output logic              io_in_sync,
    output logic              io_in_filt,
    output logic              irq_pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic                   filt_q;
    logic                   filt_prev_q;
    logic                   pend_q;
    logic [FILT_W-1:0]      cnt_q;
    logic                   filt_d;
    logic [FILT_W-1:0]      cnt_d;
    logic                   edge_hit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_in_raw};
        end
    end

    // Using >= lets a lowered filt_len take effect on the next mismatch.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (!filt_en) begin
            filt_d = sync_bit;
            cnt_d  = '0;
        end else if (sync_bit == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= filt_len) begin
            filt_d = sync_bit;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    assign edge_hit = !hold && edge_match(edge_mode, filt_prev_q, filt_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
        end else begin
            if (!hold) begin
                filt_q      <= filt_d;
                filt_prev_q <= filt_q;
                cnt_q       <= cnt_d;
            end
            pend_q <= edge_hit || (pend_q && !irq_clr);
        end
    end

    assign io_in_sync  = sync_bit;
    assign io_in_filt  = filt_q;
    assign irq_pending = pend_q;

endmodule

// File: rtl/mprj_io_cond.sv
// Input-conditioning stage for the user-project GPIO pads: one channel per pad
// plus registered per-area interrupt summaries.
module mprj_io_cond
    import mprj_io_pkg::*;
#(
    parameter int TOTAL_PADS  = MPRJ_TOTAL_PADS_DEF,
    parameter int AREA1PADS   = MPRJ_AREA1_PADS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_W      = FILT_W_DEF
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [TOTAL_PADS-1:0]   io_in_raw,
    input  logic [TOTAL_PADS-1:0]   filt_en,
    input  logic [FILT_W-1:0]       filt_len,
    input  logic [2*TOTAL_PADS-1:0] edge_mode,
    input  logic [TOTAL_PADS-1:0]   irq_clr,
    input  logic                    hold,
    output logic [TOTAL_PADS-1:0]   io_in_sync,
    output logic [TOTAL_PADS-1:0]   io_in_filt,
    output logic [TOTAL_PADS-1:0]   irq_pending,
    output logic                    area1_irq,
    output logic                    area2_irq
);

    for (genvar i = 0; i < TOTAL_PADS; i++) begin : g_ch
        mprj_io_cond_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_ch (
            .clock       (clock),
            .resetn      (resetn),
            .io_in_raw   (io_in_raw[i]),
            .filt_en     (filt_en[i]),
            .filt_len    (filt_len),
            .edge_mode   (edge_mode[2*i +: 2]),
            .irq_clr     (irq_clr[i]),
            .hold        (hold),
            .io_in_sync  (io_in_sync[i]),
            .io_in_filt  (io_in_filt[i]),
            .irq_pending (irq_pending[i])
        );
    end

    // Summaries keep tracking the flags during hold so clears are still seen.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            area1_irq <= 1'b0;
            area2_irq <= 1'b0;
        end else begin
            area1_irq <= |irq_pending[AREA1PADS-1:0];
            area2_irq <= |irq_pending[TOTAL_PADS-1:AREA1PADS];
        end
    end

endmodule

// File: tb/tb_mprj_io_cond.sv
// Bench for mprj_io_cond: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_mprj_io_cond;

    localparam int TP = 38;
    localparam int A1 = 19;
    localparam int SS = 2;
    localparam int FW = 4;
    localparam int EW = 2 * TP;
    localparam logic [TP-1:0] ALL1 = '1;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [TP-1:0]   io_in_raw = '0;
    logic [TP-1:0]   filt_en = '0;
    logic [FW-1:0]   filt_len = '0;
    logic [EW-1:0]   edge_mode = '0;
    logic [TP-1:0]   irq_clr = '0;
    logic            hold = 1'b0;
    logic [TP-1:0]   io_in_sync;
    logic [TP-1:0]   io_in_filt;
    logic [TP-1:0]   irq_pending;
    logic            area1_irq;
    logic            area2_irq;

    int check_count = 0;
    int error_count = 0;
    bit score_en = 1'b0;

    // Reference model: raw-sample delay queue, filtered level, run length of
    // consecutive samples disagreeing with it, and sticky flags.
    logic [TP-1:0] m_raw_q[$];
    logic [TP-1:0] m_filt;
    logic [TP-1:0] m_prev;
    logic [TP-1:0] m_pend;
    int            m_run[TP];
    logic          m_area1;
    logic          m_area2;

    mprj_io_cond #(
        .TOTAL_PADS  (TP),
        .AREA1PADS   (A1),
        .SYNC_STAGES (SS),
        .FILT_W      (FW)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .io_in_raw   (io_in_raw),
        .filt_en     (filt_en),
        .filt_len    (filt_len),
        .edge_mode   (edge_mode),
        .irq_clr     (irq_clr),
        .hold        (hold),
        .io_in_sync  (io_in_sync),
        .io_in_filt  (io_in_filt),
        .irq_pending (irq_pending),
        .area1_irq   (area1_irq),
        .area2_irq   (area2_irq)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [TP-1:0] raw, input logic [TP-1:0] clr,
                                 input logic hld, input int cycles);
        io_in_raw = raw;
        irq_clr   = clr;
        hold      = hld;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic model_reset();
        m_raw_q.delete();
        repeat (SS) m_raw_q.push_back('0);
        m_filt  = '0;
        m_prev  = '0;
        m_pend  = '0;
        m_area1 = 1'b0;
        m_area2 = 1'b0;
        foreach (m_run[i]) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [TP-1:0] s;
        logic [TP-1:0] f_new;
        logic [TP-1:0] p_new;
        logic [1:0]    mode;
        bit            wanted;
        s = m_raw_q[0];
        m_area1 = 1'b0;
        m_area2 = 1'b0;
        for (int i = 0; i < TP; i++) begin
            if (m_pend[i]) begin
                if (i < A1) m_area1 = 1'b1;
                else        m_area2 = 1'b1;
            end
        end
        for (int i = 0; i < TP; i++) begin
            mode   = edge_mode[2*i +: 2];
            wanted = m_filt[i] ? mode[0] : mode[1];
            p_new[i] = (!hold && (m_filt[i] != m_prev[i]) && wanted) || (m_pend[i] && !irq_clr[i]);
        end
        f_new = m_filt;
        if (!hold) begin
            for (int i = 0; i < TP; i++) begin
                if (!filt_en[i]) begin
                    f_new[i] = s[i];
                    m_run[i] = 0;
                end else if (s[i] == m_filt[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] > int'(filt_len)) begin
                        f_new[i] = s[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_prev = m_filt;
            m_filt = f_new;
        end
        m_pend = p_new;
        m_raw_q.push_back(io_in_raw);
        void'(m_raw_q.pop_front());
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) model_reset();
        else         model_step();
    end

    always @(negedge clock) begin
        if (score_en) begin
            checkOutput("sb_sync",  64'(io_in_sync),  64'(m_raw_q[0]));
            checkOutput("sb_filt",  64'(io_in_filt),  64'(m_filt));
            checkOutput("sb_pend",  64'(irq_pending), 64'(m_pend));
            checkOutput("sb_area1", 64'(area1_irq),   64'(m_area1));
            checkOutput("sb_area2", 64'(area2_irq),   64'(m_area2));
        end
    end

    initial begin
        #400000;
        error_count++;
        $display("[TB] FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

    initial begin
        logic [TP-1:0] raw;
        logic [TP-1:0] clr;
        logic          hld;
        int            wait_cnt;

        // Reset with all pads high: everything reads zero until release.
        io_in_raw = ALL1;
        repeat (3) @(negedge clock);
        score_en = 1'b1;
        checkOutput("rst_sync",  64'(io_in_sync),  64'd0);
        checkOutput("rst_filt",  64'(io_in_filt),  64'd0);
        checkOutput("rst_pend",  64'(irq_pending), 64'd0);
        checkOutput("rst_area1", 64'(area1_irq),   64'd0);
        checkOutput("rst_area2", 64'(area2_irq),   64'd0);
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("sync_lat1", 64'(io_in_sync), 64'd0);
        @(negedge clock);
        checkOutput("sync_lat2", 64'(io_in_sync), 64'(ALL1));
        raw = '0;
        applyStimulus(raw, '0, 1'b0, 6);

        // Debounce on pad 3, length 4, rising edges only.
        filt_en = '0; filt_en[3] = 1'b1; filt_len = 4'd4;
        edge_mode = '0; edge_mode[7:6] = 2'b01;
        raw[3] = 1'b1;
        applyStimulus(raw, '0, 1'b0, 4);
        raw[3] = 1'b0;
        applyStimulus(raw, '0, 1'b0, 8);
        checkOutput("glitch_filt", 64'(io_in_filt[3]),  64'd0);
        checkOutput("glitch_pend", 64'(irq_pending[3]), 64'd0);
        raw[3] = 1'b1;
        io_in_raw = raw;
        wait_cnt = 0;
        while (!io_in_sync[3] && wait_cnt < 10) begin @(negedge clock); wait_cnt++; end
        checkOutput("sync3_lat", 64'(wait_cnt), 64'(SS));
        wait_cnt = 0;
        while (!io_in_filt[3] && wait_cnt < 20) begin @(negedge clock); wait_cnt++; end
        checkOutput("filt3_lat", 64'(wait_cnt), 64'd5);
        checkOutput("pend3_early", 64'(irq_pending[3]), 64'd0);
        @(negedge clock);
        checkOutput("pend3_set", 64'(irq_pending[3]), 64'd1);
        checkOutput("area1_early", 64'(area1_irq), 64'd0);
        @(negedge clock);
        checkOutput("area1_set", 64'(area1_irq), 64'd1);
        checkOutput("area2_quiet", 64'(area2_irq), 64'd0);
        raw[3] = 1'b0;
        applyStimulus(raw, ALL1, 1'b0, 1);
        applyStimulus(raw, '0, 1'b0, 10);
        checkOutput("fall3_ignored", 64'(irq_pending[3]), 64'd0);

        // Pad 20 in area 2: falling edges only, then mode off.
        filt_en = '0; edge_mode = '0; edge_mode[41:40] = 2'b10;
        raw[20] = 1'b1;
        applyStimulus(raw, '0, 1'b0, 6);
        checkOutput("rise20_ignored", 64'(irq_pending[20]), 64'd0);
        raw[20] = 1'b0;
        applyStimulus(raw, '0, 1'b0, 6);
        checkOutput("fall20_pend",  64'(irq_pending[20]), 64'd1);
        checkOutput("fall20_area2", 64'(area2_irq), 64'd1);
        checkOutput("fall20_area1", 64'(area1_irq), 64'd0);
        applyStimulus(raw, ALL1, 1'b0, 1);
        applyStimulus(raw, '0, 1'b0, 3);
        checkOutput("clr20", 64'(irq_pending[20]), 64'd0);
        edge_mode[41:40] = 2'b00;
        raw[20] = 1'b1;
        applyStimulus(raw, '0, 1'b0, 6);
        raw[20] = 1'b0;
        applyStimulus(raw, '0, 1'b0, 6);
        checkOutput("off20_pend",  64'(irq_pending[20]), 64'd0);
        checkOutput("off20_area2", 64'(area2_irq), 64'd0);

        // Set and clear landing on the same cycle on pad 0: set wins.
        edge_mode = '0; edge_mode[1:0] = 2'b11;
        raw[0] = 1'b1;
        io_in_raw = raw;
        wait_cnt = 0;
        while (!io_in_filt[0] && wait_cnt < 10) begin @(negedge clock); wait_cnt++; end
        checkOutput("filt0_lat", 64'(wait_cnt), 64'd3);
        irq_clr[0] = 1'b1;
        @(negedge clock);
        checkOutput("collide_pend", 64'(irq_pending[0]), 64'd1);
        @(negedge clock);
        checkOutput("clr0_pend",  64'(irq_pending[0]), 64'd0);
        checkOutput("clr0_area1", 64'(area1_irq), 64'd1);
        irq_clr = '0;
        @(negedge clock);
        checkOutput("clr0_area1_low", 64'(area1_irq), 64'd0);
        raw[0] = 1'b0;
        applyStimulus(raw, '0, 1'b0, 6);
        applyStimulus(raw, ALL1, 1'b0, 1);
        applyStimulus(raw, '0, 1'b0, 3);

        // Hold freezes pad 5 while clears still apply.
        filt_en = '0; filt_en[5] = 1'b1; filt_len = 4'd4;
        edge_mode = '0; edge_mode[11:10] = 2'b01;
        raw[5] = 1'b1;
        applyStimulus(raw, ALL1, 1'b1, 20);
        checkOutput("hold_sync5", 64'(io_in_sync[5]), 64'd1);
        checkOutput("hold_filt5", 64'(io_in_filt[5]), 64'd0);
        checkOutput("hold_pend",  64'(irq_pending), 64'd0);
        irq_clr = '0;
        hold = 1'b0;
        wait_cnt = 0;
        while (!io_in_filt[5] && wait_cnt < 20) begin @(negedge clock); wait_cnt++; end
        checkOutput("release_filt5", 64'(wait_cnt), 64'd5);
        @(negedge clock);
        checkOutput("release_pend5", 64'(irq_pending[5]), 64'd1);
        raw[5] = 1'b0;
        applyStimulus(raw, '0, 1'b0, 10);
        applyStimulus(raw, ALL1, 1'b0, 1);
        applyStimulus(raw, '0, 1'b0, 3);

        // Async reset mid-debounce on pad 7 with its flag pending.
        filt_en = '0; filt_en[7] = 1'b1;
        edge_mode = '0; edge_mode[15:14] = 2'b01;
        raw[7] = 1'b1;
        applyStimulus(raw, '0, 1'b0, 10);
        checkOutput("pre_rst_pend7", 64'(irq_pending[7]), 64'd1);
        raw[7] = 1'b0;
        io_in_raw = raw;
        wait_cnt = 0;
        while (io_in_sync[7] && wait_cnt < 10) begin @(negedge clock); wait_cnt++; end
        repeat (3) @(negedge clock);
        checkOutput("pre_rst_filt7", 64'(io_in_filt[7]), 64'd1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst_pend7",  64'(irq_pending[7]), 64'd0);
        checkOutput("rst_filt7",  64'(io_in_filt[7]), 64'd0);
        checkOutput("rst_area1b", 64'(area1_irq), 64'd0);
        #1 resetn = 1'b1;
        @(negedge clock);
        raw[7] = 1'b1;
        io_in_raw = raw;
        wait_cnt = 0;
        while (!io_in_filt[7] && wait_cnt < 20) begin @(negedge clock); wait_cnt++; end
        checkOutput("restart_filt7", 64'(wait_cnt), 64'd7);

        // Randomized traffic with mid-run length changes, holds and a reset.
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                filt_en   = TP'({$urandom, $urandom});
                edge_mode = EW'({$urandom, $urandom, $urandom});
            end
            if (c % 25 == 0) filt_len = FW'($urandom_range(0, 6));
            raw = io_in_raw;
            clr = '0;
            for (int i = 0; i < TP; i++) begin
                if ($urandom_range(0, 7) == 0)  raw[i] = ~raw[i];
                if ($urandom_range(0, 15) == 0) clr[i] = 1'b1;
            end
            hld = ($urandom_range(0, 29) == 0) ? ~hold : hold;
            applyStimulus(raw, clr, hld, 1);
            if (c == 700) begin
                #2 resetn = 1'b0;
                #2 resetn = 1'b1;
            end
        end

        score_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
